// File: rtl/ariane_pkg.sv
// Shared core types: functional units, ALU ops, exceptions and scoreboard entries.
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES = 8;

  typedef enum logic [1:0] {
    FuNone,
    FuAlu,
    FuLsu,
    FuBranch
  } fu_t;

  typedef enum logic [2:0] {
    OpAdd,
    OpSub,
    OpXor,
    OpOr,
    OpAnd,
    OpSll,
    OpSrl,
    OpSra
  } alu_op;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [4:0]  trans_id;
    fu_t         fu;
    alu_op       op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    exception    ex;
  } scoreboard_entry;

endpackage

// File: rtl/scoreboard.sv
// In-order issue / out-of-order writeback / in-order commit scoreboard kept as a
// circular buffer of scoreboard entries addressed by commit, issue and write pointers.
module scoreboard
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = NR_SB_ENTRIES
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  scoreboard_entry decoded_instr_i,
  input  logic            decoded_instr_valid_i,
  output logic            decoded_instr_ack_o,
  output scoreboard_entry issue_instr_o,
  output logic            issue_instr_valid_o,
  input  logic            issue_ack_i,
  input  logic            wb_valid_i,
  input  logic [4:0]      trans_id_i,
  input  logic [63:0]     wdata_i,
  input  exception        ex_i,
  output scoreboard_entry commit_instr_o,
  output logic            commit_valid_o,
  input  logic            commit_ack_i,
  output logic [31:0]     rd_busy_o
);

  localparam int unsigned IdxW = $clog2(NR_ENTRIES);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [IdxW:0]   cnt_t;

  localparam cnt_t Full = cnt_t'(NR_ENTRIES);

  if (NR_ENTRIES < 2 || NR_ENTRIES > 32 || (NR_ENTRIES & (NR_ENTRIES - 1)) != 0) begin : gen_bad
    $error("NR_ENTRIES must be a power of two between 2 and 32");
  end

  scoreboard_entry mem_q [NR_ENTRIES];
  scoreboard_entry mem_d [NR_ENTRIES];
  idx_t            commit_ptr_q, commit_ptr_d;
  idx_t            issue_ptr_q, issue_ptr_d;
  idx_t            write_ptr_q, write_ptr_d;
  cnt_t            count_q, count_d;
  // Number of occupied entries already handed to a functional unit; distinguishes
  // full-and-unissued from full-and-all-issued when the pointers coincide.
  cnt_t            issued_q, issued_d;

  logic [NR_ENTRIES-1:0] occupied;
  logic [NR_ENTRIES-1:0] issued;
  scoreboard_entry       new_entry;
  logic                  accept;
  logic                  do_issue;
  logic                  do_commit;
  logic                  wb_ok;
  idx_t                  wb_idx;
  logic [31:0]           rd_busy;
  logic                  unused_trans_id;

  assign wb_idx          = trans_id_i[IdxW-1:0];
  assign unused_trans_id = ^trans_id_i;

  // Slot age relative to the head decides whether it is occupied and/or issued.
  always_comb begin
    occupied = '0;
    issued   = '0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      occupied[i] = cnt_t'(idx_t'(idx_t'(i) - commit_ptr_q)) < count_q;
      issued[i]   = cnt_t'(idx_t'(idx_t'(i) - commit_ptr_q)) < issued_q;
    end
  end

  assign accept    = decoded_instr_valid_i && (count_q < Full) && !flush_i && !rst_i;
  assign do_issue  = issue_instr_valid_o && issue_ack_i;
  assign do_commit = commit_valid_o && commit_ack_i;
  assign wb_ok     = wb_valid_i && occupied[wb_idx] && issued[wb_idx];

  assign decoded_instr_ack_o = accept;
  assign issue_instr_valid_o = issued_q < count_q;
  assign issue_instr_o       = mem_q[issue_ptr_q];
  assign commit_valid_o      = (count_q != '0) && mem_q[commit_ptr_q].valid;
  assign commit_instr_o      = mem_q[commit_ptr_q];

  always_comb begin
    new_entry          = decoded_instr_i;
    new_entry.trans_id = 5'(write_ptr_q);
    new_entry.valid    = 1'b0;
  end

  always_comb begin
    mem_d        = mem_q;
    commit_ptr_d = commit_ptr_q;
    issue_ptr_d  = issue_ptr_q;
    write_ptr_d  = write_ptr_q;
    count_d      = count_q;
    issued_d     = issued_q;
    if (flush_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        mem_d[i] = '0;
      end
      commit_ptr_d = '0;
      issue_ptr_d  = '0;
      write_ptr_d  = '0;
      count_d      = '0;
      issued_d     = '0;
    end else begin
      if (accept) begin
        mem_d[write_ptr_q] = new_entry;
        write_ptr_d        = write_ptr_q + idx_t'(1);
      end
      if (wb_ok) begin
        mem_d[wb_idx].result = wdata_i;
        mem_d[wb_idx].ex     = ex_i;
        mem_d[wb_idx].valid  = 1'b1;
      end
      if (do_issue) begin
        issue_ptr_d = issue_ptr_q + idx_t'(1);
      end
      if (do_commit) begin
        mem_d[commit_ptr_q] = '0;
        commit_ptr_d        = commit_ptr_q + idx_t'(1);
      end
      count_d  = count_q + cnt_t'(accept) - cnt_t'(do_commit);
      issued_d = issued_q + cnt_t'(do_issue) - cnt_t'(do_commit);
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      if (occupied[i]) begin
        rd_busy[mem_q[i].rd] = 1'b1;
      end
    end
    rd_busy[0] = 1'b0;
  end

  assign rd_busy_o = rd_busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
      commit_ptr_q <= '0;
      issue_ptr_q  <= '0;
      write_ptr_q  <= '0;
      count_q      <= '0;
      issued_q     <= '0;
    end else begin
      mem_q        <= mem_d;
      commit_ptr_q <= commit_ptr_d;
      issue_ptr_q  <= issue_ptr_d;
      write_ptr_q  <= write_ptr_d;
      count_q      <= count_d;
      issued_q     <= issued_d;
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for the scoreboard: directed scenarios plus a randomized run
// compared against an in-order queue model of the instruction window.
module tb_scoreboard;
  import ariane_pkg::*;

  localparam int N = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  scoreboard_entry dinstr;
  logic            dvalid;
  logic            dack;
  scoreboard_entry iinstr;
  logic            ivalid;
  logic            iack;
  logic            wbv;
  logic [4:0]      tid;
  logic [63:0]     wdata;
  exception        ex;
  scoreboard_entry cinstr;
  logic            cvalid;
  logic            cack;
  logic [31:0]     busy;

  int n_tests = 0;
  int n_fail  = 0;

  scoreboard #(.NR_ENTRIES(N)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .flush_i              (flush),
    .decoded_instr_i      (dinstr),
    .decoded_instr_valid_i(dvalid),
    .decoded_instr_ack_o  (dack),
    .issue_instr_o        (iinstr),
    .issue_instr_valid_o  (ivalid),
    .issue_ack_i          (iack),
    .wb_valid_i           (wbv),
    .trans_id_i           (tid),
    .wdata_i              (wdata),
    .ex_i                 (ex),
    .commit_instr_o       (cinstr),
    .commit_valid_o       (cvalid),
    .commit_ack_i         (cack),
    .rd_busy_o            (busy)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered window of in-flight instructions.
  typedef struct {
    scoreboard_entry e;
    bit              issued;
  } m_t;

  m_t q[$];
  int wptr = 0;

  function automatic bit m_ack();
    return dvalid && (q.size() < N) && !flush && !rst;
  endfunction

  function automatic int m_issue_idx();
    for (int k = 0; k < q.size(); k++) if (!q[k].issued) return k;
    return -1;
  endfunction

  function automatic bit m_commit_valid();
    return (q.size() > 0) && q[0].e.valid;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int k = 0; k < q.size(); k++) b[q[k].e.rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  function automatic scoreboard_entry rand_instr();
    scoreboard_entry e;
    e.trans_id = 5'($urandom);
    e.fu       = fu_t'(2'($urandom));
    e.op       = alu_op'(3'($urandom));
    e.rs1      = 5'($urandom);
    e.rs2      = 5'($urandom);
    e.rd       = 5'($urandom);
    e.result   = {$urandom, $urandom};
    e.valid    = 1'b1;
    e.ex.cause = {$urandom, $urandom};
    e.ex.tval  = {$urandom, $urandom};
    e.ex.valid = 1'($urandom);
    return e;
  endfunction

  task automatic idle();
    flush  = 1'b0;
    dvalid = 1'b0;
    dinstr = '0;
    iack   = 1'b0;
    wbv    = 1'b0;
    tid    = '0;
    wdata  = '0;
    ex     = '0;
    cack   = 1'b0;
  endtask

  // Clock one edge and advance the model with the inputs that were applied.
  task automatic cycle();
    bit a  = m_ack();
    int ii = m_issue_idx();
    bit cv = m_commit_valid();
    @(posedge clk);
    if (flush) begin
      q.delete();
      wptr = 0;
    end else begin
      if (wbv) begin
        for (int k = 0; k < q.size(); k++) begin
          if (q[k].issued && (int'(q[k].e.trans_id) % N) == (int'(tid) % N)) begin
            m_t t = q[k];
            t.e.result = wdata;
            t.e.ex     = ex;
            t.e.valid  = 1'b1;
            q[k]       = t;
          end
        end
      end
      if (ii >= 0 && iack) q[ii].issued = 1'b1;
      if (cv && cack) void'(q.pop_front());
      if (a) begin
        m_t t;
        t.e          = dinstr;
        t.e.trans_id = 5'(wptr);
        t.e.valid    = 1'b0;
        t.issued     = 1'b0;
        q.push_back(t);
        wptr = (wptr + 1) % N;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    wptr = 0;
  endtask

  task automatic accept_one(input logic [4:0] rd);
    idle();
    dvalid    = 1'b1;
    dinstr    = rand_instr();
    dinstr.rd = rd;
    cycle();
  endtask

  task automatic test_reset();
    idle();
    rst    = 1'b1;
    dvalid = 1'b1;
    #2;
    n_tests++; if (dack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", dack); end
    n_tests++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL reset_ivalid: got %b want 0", ivalid); end
    n_tests++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL reset_cvalid: got %b want 0", cvalid); end
    n_tests++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    dvalid = 1'b1; dinstr = rand_instr(); dinstr.op = OpAdd; dinstr.fu = FuAlu; dinstr.rd = 5'd5;
    #1;
    n_tests++; if (dack !== 1'b1) begin n_fail++; $display("FAIL basic_ack: got %b want 1", dack); end
    n_tests++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass: got %b want 0", ivalid); end
    cycle();
    idle(); iack = 1'b1; #1;
    n_tests++; if (ivalid !== 1'b1) begin n_fail++; $display("FAIL basic_ivalid: got %b want 1", ivalid); end
    n_tests++; if (iinstr.trans_id !== 5'd0) begin n_fail++; $display("FAIL basic_tid: got %0d want 0", iinstr.trans_id); end
    n_tests++; if (busy !== 32'h20) begin n_fail++; $display("FAIL basic_busy: got %h want 00000020", busy); end
    cycle();
    idle(); wbv = 1'b1; tid = 5'd0; wdata = 64'h2A; #1;
    n_tests++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL basic_wb_same_cycle: got %b want 0", cvalid); end
    cycle();
    idle(); cack = 1'b1; #1;
    n_tests++; if (cvalid !== 1'b1) begin n_fail++; $display("FAIL basic_cvalid: got %b want 1", cvalid); end
    n_tests++; if (cinstr.result !== 64'h2A) begin n_fail++; $display("FAIL basic_result: got %h want 2a", cinstr.result); end
    cycle();
    idle(); #1;
    n_tests++; if (busy !== 32'h0) begin n_fail++; $display("FAIL basic_busy_clear: got %h want 0", busy); end
    n_tests++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL basic_cvalid_clear: got %b want 0", cvalid); end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < N; i++) accept_one(5'($urandom));
    idle(); dvalid = 1'b1; dinstr = rand_instr(); iack = 1'b1; #1;
    n_tests++; if (dack !== 1'b0) begin n_fail++; $display("FAIL full_ack: got %b want 0", dack); end
    n_tests++; if (ivalid !== 1'b1) begin n_fail++; $display("FAIL full_ivalid: got %b want 1", ivalid); end
    cycle();
    idle(); wbv = 1'b1; tid = 5'd0; wdata = {$urandom, $urandom}; dvalid = 1'b1; cycle();
    idle(); dvalid = 1'b1; dinstr = rand_instr(); cack = 1'b1; #1;
    n_tests++; if (cvalid !== 1'b1) begin n_fail++; $display("FAIL full_cvalid: got %b want 1", cvalid); end
    n_tests++; if (dack !== 1'b0) begin n_fail++; $display("FAIL full_commit_same_cycle: got %b want 0", dack); end
    cycle();
    idle(); dvalid = 1'b1; dinstr = rand_instr(); #1;
    n_tests++; if (dack !== 1'b1) begin n_fail++; $display("FAIL full_ack_after: got %b want 1", dack); end
    cycle();
    for (int j = 1; j <= N; j++) begin
      idle(); iack = 1'b1; #1;
      n_tests++;
      if (ivalid !== 1'b1 || iinstr.trans_id !== 5'(j % N)) begin
        n_fail++;
        $display("FAIL full_drain_tid: got valid %b id %0d want valid 1 id %0d", ivalid,
                 iinstr.trans_id, j % N);
      end
      cycle();
    end
  endtask

  task automatic test_out_of_order();
    logic [63:0] data [3];
    apply_reset();
    for (int i = 0; i < 3; i++) accept_one(5'(i + 10));
    for (int i = 0; i < 3; i++) begin idle(); iack = 1'b1; cycle(); end
    for (int i = 0; i < 3; i++) data[i] = {$urandom, $urandom};
    for (int i = 2; i >= 0; i--) begin
      idle(); wbv = 1'b1; tid = 5'(i); wdata = data[i]; #1;
      n_tests++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL ooo_hold_%0d: got %b want 0", i, cvalid); end
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      idle(); cack = 1'b1; #1;
      n_tests++;
      if (cvalid !== 1'b1 || cinstr.trans_id !== 5'(i) || cinstr.result !== data[i]) begin
        n_fail++;
        $display("FAIL ooo_commit_%0d: got valid %b id %0d res %h want 1 %0d %h", i, cvalid,
                 cinstr.trans_id, cinstr.result, i, data[i]);
      end
      cycle();
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 4; i++) accept_one(5'(i + 1));
    for (int i = 0; i < 2; i++) begin idle(); iack = 1'b1; cycle(); end
    idle(); flush = 1'b1; wbv = 1'b1; tid = 5'd0; wdata = 64'h55; dvalid = 1'b1;
    dinstr = rand_instr(); #1;
    n_tests++; if (dack !== 1'b0) begin n_fail++; $display("FAIL flush_ack: got %b want 0", dack); end
    cycle();
    idle(); #1;
    n_tests++;
    if (ivalid !== 1'b0 || cvalid !== 1'b0 || busy !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_clear: got ivalid %b cvalid %b busy %h want 0 0 0", ivalid, cvalid, busy);
    end
    idle(); dvalid = 1'b1; dinstr = rand_instr(); #1;
    n_tests++; if (dack !== 1'b1) begin n_fail++; $display("FAIL flush_reaccept: got %b want 1", dack); end
    cycle();
    idle(); #1;
    n_tests++;
    if (ivalid !== 1'b1 || iinstr.trans_id !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_tid: got valid %b id %0d want 1 0", ivalid, iinstr.trans_id);
    end
  endtask

  task automatic test_stray_wb();
    logic [63:0] d;
    apply_reset();
    accept_one(5'd3);
    accept_one(5'd4);
    idle(); iack = 1'b1; cycle();
    idle(); wbv = 1'b1; tid = 5'd1; wdata = 64'hBAD1; cycle();
    idle(); wbv = 1'b1; tid = 5'd5; wdata = 64'hBAD5; cycle();
    idle(); #1;
    n_tests++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL stray_cvalid: got %b want 0", cvalid); end
    n_tests++; if (busy !== 32'h18) begin n_fail++; $display("FAIL stray_busy: got %h want 00000018", busy); end
    d = {$urandom, $urandom};
    idle(); wbv = 1'b1; tid = 5'd0; wdata = d; iack = 1'b1; cycle();
    idle(); cack = 1'b1; #1;
    n_tests++;
    if (cvalid !== 1'b1 || cinstr.result !== d) begin
      n_fail++;
      $display("FAIL stray_head: got valid %b res %h want 1 %h", cvalid, cinstr.result, d);
    end
    cycle();
    idle(); #1;
    n_tests++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL stray_second: got %b want 0", cvalid); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) accept_one(5'(i + 1));
    for (int i = 0; i < 2; i++) begin idle(); iack = 1'b1; cycle(); end
    idle(); wbv = 1'b1; tid = 5'd0; wdata = 64'h1; cycle();
    idle(); dvalid = 1'b1; #1;
    n_tests++;
    if (busy !== 32'h3E || cvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_before: got busy %h cvalid %b want 0000003e 1", busy, cvalid);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (dack !== 1'b0 || ivalid !== 1'b0 || cvalid !== 1'b0 || busy !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: got ack %b ivalid %b cvalid %b busy %h want 0 0 0 0", dack,
               ivalid, cvalid, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    wptr = 0;
    idle(); #1;
    n_tests++;
    if (ivalid !== 1'b0 || cvalid !== 1'b0 || busy !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_after: got ivalid %b cvalid %b busy %h want 0 0 0", ivalid, cvalid, busy);
    end
  endtask

  task automatic test_random();
    int k;
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      idle();
      dvalid = ($urandom_range(0, 2) != 0);
      dinstr = rand_instr();
      iack   = 1'($urandom);
      cack   = 1'($urandom);
      flush  = ($urandom_range(0, 59) == 0);
      wbv    = 1'($urandom);
      tid    = 5'($urandom);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        k   = $urandom_range(0, q.size() - 1);
        tid = (tid & ~5'(N - 1)) | (q[k].e.trans_id & 5'(N - 1));
      end
      wdata = {$urandom, $urandom};
      ex    = rand_instr().ex;
      #1;
      k = m_issue_idx();
      n_tests++;
      if (dack !== m_ack()) begin
        n_fail++; $display("FAIL rand_ack c%0d: got %b want %b", c, dack, m_ack());
      end
      n_tests++;
      if (ivalid !== (k >= 0)) begin
        n_fail++; $display("FAIL rand_ivalid c%0d: got %b want %b", c, ivalid, k >= 0);
      end else if (k >= 0) begin
        n_tests++;
        if (iinstr !== q[k].e) begin
          n_fail++; $display("FAIL rand_iinstr c%0d: got %h want %h", c, iinstr, q[k].e);
        end
      end
      n_tests++;
      if (cvalid !== m_commit_valid()) begin
        n_fail++; $display("FAIL rand_cvalid c%0d: got %b want %b", c, cvalid, m_commit_valid());
      end else if (m_commit_valid()) begin
        n_tests++;
        if (cinstr !== q[0].e) begin
          n_fail++; $display("FAIL rand_cinstr c%0d: got %h want %h", c, cinstr, q[0].e);
        end
      end
      n_tests++;
      if (busy !== m_busy()) begin
        n_fail++; $display("FAIL rand_busy c%0d: got %h want %h", c, busy, m_busy());
      end
      cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_out_of_order();
    test_flush();
    test_stray_wb();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scoreboard.md
SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 8, meaning the number of in-flight scoreboard_entry slots; must be a power of two, 2..32.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port flush_i, input, 1 bit: discard all entries.
REQ-005 SHALL have port decoded_instr_i, input, scoreboard_entry: the instruction from decode.
REQ-006 SHALL have port decoded_instr_valid_i, input, 1 bit: decode offers an instruction.
REQ-007 SHALL have port decoded_instr_ack_o, output, 1 bit: the slot was accepted this cycle.
REQ-008 SHALL have port issue_instr_o, output, scoreboard_entry: the oldest unissued entry.
REQ-009 SHALL have port issue_instr_valid_o, output, 1 bit: issue_instr_o is meaningful.
REQ-010 SHALL have port issue_ack_i, input, 1 bit: a functional unit took issue_instr_o.
REQ-011 SHALL have port wb_valid_i, input, 1 bit: writeback strobe.
REQ-012 SHALL have port trans_id_i, input, 5 bits: the writeback target slot.
REQ-013 SHALL have port wdata_i, input, 64 bits: the writeback result.
REQ-014 SHALL have port ex_i, input, exception: the writeback exception.
REQ-015 SHALL have port commit_instr_o, output, scoreboard_entry: the oldest entry.
REQ-016 SHALL have port commit_valid_o, output, 1 bit: the head has a result and may commit.
REQ-017 SHALL have port commit_ack_i, input, 1 bit: commit retires the head.
REQ-018 SHALL have port rd_busy_o, output, 32 bits: per-register pending-write mask.

Function
REQ-019 SHALL store entries in a circular buffer with commit_ptr, issue_ptr, write_ptr (each log2(NR_ENTRIES) bits, wrapping modulo NR_ENTRIES) and a count from 0 to NR_ENTRIES.
REQ-020 SHALL drive decoded_instr_ack_o = decoded_instr_valid_i && count < NR_ENTRIES; a commit in the same cycle SHALL NOT free a slot for a same-cycle accept.
REQ-021 On accept SHALL write decoded_instr_i at write_ptr with trans_id forced to write_ptr and valid forced to 0, then increment write_ptr.
REQ-022 SHALL drive issue_instr_valid_o = (issue_ptr != write_ptr or the buffer is full with nothing issued); issue_instr_o = entry[issue_ptr].
REQ-023 SHALL advance issue_ptr on issue_instr_valid_o && issue_ack_i; issue is strictly in order.
REQ-024 An accepted instruction SHALL appear on the issue port no earlier than the next cycle (no same-cycle bypass).
REQ-025 On wb_valid_i SHALL write wdata_i into result and ex_i into ex of entry[trans_id_i[log2(NR_ENTRIES)-1:0]] and set its valid, only if that slot is occupied and already issued; otherwise the write is ignored.
REQ-026 SHALL drive commit_valid_o = count > 0 && entry[commit_ptr].valid; commit_instr_o = entry[commit_ptr].
REQ-027 A writeback in cycle N to the head SHALL raise commit_valid_o in cycle N+1, not N.
REQ-028 On commit_valid_o && commit_ack_i SHALL clear the head slot and increment commit_ptr.
REQ-029 SHALL update count as +1 on accept and -1 on commit; both in one cycle leave it unchanged.
REQ-030 SHALL set rd_busy_o[r] when any occupied slot has rd == r; rd_busy_o[0] SHALL be 0 always.
REQ-031 flush_i SHALL override accept, issue, writeback and commit in that cycle: pointers and count go to 0, all slots are cleared, and decoded_instr_ack_o is forced to 0 in the flush cycle.
REQ-032 Outputs are combinational from state; there is no internal stall or state machine beyond the pointers.

Reset
REQ-033 rst_i SHALL asynchronously clear pointers, count and every slot, including valid bits.
REQ-034 During and after reset, issue_instr_valid_o, commit_valid_o, decoded_instr_ack_o and rd_busy_o SHALL be 0 until new activity.

Structure
REQ-035 scoreboard_entry, fu_t, alu_op and exception SHALL come from ariane_pkg.
REQ-036 A localparam NR_SB_ENTRIES = 8 SHALL be added to ariane_pkg and used as the default for NR_ENTRIES.
REQ-037 No sub-module is required; pointer, count and storage logic stay in scoreboard.

Verification
REQ-038 Scenario (basic flow): accept ADD, rd=5 -> trans_id=0; issue valid next cycle; rd_busy_o[5]=1; wb id 0 data 0x2A -> commit next cycle with result 0x2A; after ack rd_busy_o=0.
REQ-039 Scenario (full): fill 8 entries with no commits -> ack=0 on the 9th; a commit in that same cycle still leaves ack=0; the next cycle the accept succeeds with trans_id=0 (wrap).
REQ-040 Scenario (out-of-order writeback): 3 issued; wb id 2 then id 1 -> commit_valid_o stays 0; wb id 0 -> commits in order 0, 1, 2.
REQ-041 Scenario (flush): 4 entries and simultaneous wb + decode valid, assert flush_i -> next cycle all valids 0, count 0, the next accept gets trans_id=0.
REQ-042 Scenario (stray writeback): wb to an empty slot or an unissued slot -> no state change; no commit_valid_o.
REQ-043 Scenario (reset mid-operation): rst_i pulse with 5 in flight -> all outputs 0 immediately, asynchronously.
